key_panel: RTL

Parametrised front-panel key processor for the DE2-115 audio designs.
- Replaces per-key single-output debouncers with an N-channel bank.
- Each channel synchronises a raw push-button and debounces it, then emits one-cycle press, release, click, long-press and auto-repeat events.
- Sits between the board KEY pins and the recorder/player control (Top) in the 12 MHz domain.

---
 rtl/key_panel_pkg.sv | 19 +
 rtl/key_channel.sv | 122 ++++++++++++
 rtl/key_panel.sv | 43 ++++
 3 files changed

// File: rtl/key_panel_pkg.sv
// Shared types and helpers for the front-panel key processor.
package key_panel_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    HELD    = 2'd2
  } key_state_e;

  // Bits needed to hold 0..n-1; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/key_channel.sv
// One key: 2-flop synchroniser, debouncer and press/long/repeat event FSM.
module key_channel
  import key_panel_pkg::*;
#(
  parameter int unsigned ACTIVE_LOW    = 1,
  parameter int unsigned DEB_CYCLES    = 240000,
  parameter int unsigned LONG_CYCLES   = 12000000,
  parameter int unsigned REPEAT_CYCLES = 2400000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_key,
  input  logic i_repeat_en,
  output logic o_level,
  output logic o_press,
  output logic o_release,
  output logic o_click,
  output logic o_long,
  output logic o_repeat
);

  localparam int unsigned DW = cnt_width(DEB_CYCLES);
  localparam int unsigned HW = cnt_width(max_u(LONG_CYCLES, REPEAT_CYCLES));
  localparam logic INV = (ACTIVE_LOW != 0);
  localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);
  localparam logic [HW-1:0] LONG_LAST = HW'(LONG_CYCLES - 1);
  localparam logic [HW-1:0] REP_LAST = HW'(REPEAT_CYCLES - 1);

  logic          sync1, sync2;
  logic [DW-1:0] dc;
  logic [HW-1:0] hc;
  key_state_e    state;

  logic s_c, accept_c, press_c, release_c;

  assign s_c       = sync2 ^ INV;
  assign accept_c  = (s_c != o_level) && (dc == DEB_LAST);
  assign press_c   = accept_c & s_c;
  assign release_c = accept_c & ~s_c;

  // Synchroniser resets to the released pin level so reset never looks like a press.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync1 <= INV;
      sync2 <= INV;
    end else begin
      sync1 <= i_key;
      sync2 <= sync1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      dc        <= '0;
      o_level   <= 1'b0;
      o_press   <= 1'b0;
      o_release <= 1'b0;
    end else begin
      o_press   <= press_c;
      o_release <= release_c;
      if (s_c == o_level) begin
        dc <= '0;
      end else if (dc == DEB_LAST) begin
        o_level <= s_c;
        dc      <= '0;
      end else begin
        dc <= dc + DW'(1);
      end
    end
  end

  // Release takes priority over any terminal count reached on the same edge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state    <= IDLE;
      hc       <= '0;
      o_click  <= 1'b0;
      o_long   <= 1'b0;
      o_repeat <= 1'b0;
    end else begin
      o_click  <= 1'b0;
      o_long   <= 1'b0;
      o_repeat <= 1'b0;
      if (release_c) begin
        o_click <= (state == PRESSED);
        state   <= IDLE;
        hc      <= '0;
      end else begin
        case (state)
          IDLE: begin
            hc <= '0;
            if (press_c) state <= PRESSED;
          end
          PRESSED: begin
            if (hc == LONG_LAST) begin
              o_long <= 1'b1;
              state  <= HELD;
              hc     <= '0;
            end else begin
              hc <= hc + HW'(1);
            end
          end
          HELD: begin
            if (!i_repeat_en) begin
              hc <= '0;
            end else if (hc == REP_LAST) begin
              o_repeat <= 1'b1;
              hc       <= '0;
            end else begin
              hc <= hc + HW'(1);
            end
          end
          default: begin
            state <= IDLE;
            hc    <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/key_panel.sv
// N-channel bank of independent key processors.
module key_panel
  import key_panel_pkg::*;
#(
  parameter int unsigned N_KEYS        = 4,
  parameter int unsigned ACTIVE_LOW    = 1,
  parameter int unsigned DEB_CYCLES    = 240000,
  parameter int unsigned LONG_CYCLES   = 12000000,
  parameter int unsigned REPEAT_CYCLES = 2400000
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [N_KEYS-1:0] i_key,
  input  logic [N_KEYS-1:0] i_repeat_en,
  output logic [N_KEYS-1:0] o_level,
  output logic [N_KEYS-1:0] o_press,
  output logic [N_KEYS-1:0] o_release,
  output logic [N_KEYS-1:0] o_click,
  output logic [N_KEYS-1:0] o_long,
  output logic [N_KEYS-1:0] o_repeat
);

  for (genvar k = 0; k < int'(N_KEYS); k++) begin : g_ch
    key_channel #(
      .ACTIVE_LOW   (ACTIVE_LOW),
      .DEB_CYCLES   (DEB_CYCLES),
      .LONG_CYCLES  (LONG_CYCLES),
      .REPEAT_CYCLES(REPEAT_CYCLES)
    ) u_ch (
      .i_clk      (i_clk),
      .i_rst_n    (i_rst_n),
      .i_key      (i_key[k]),
      .i_repeat_en(i_repeat_en[k]),
      .o_level    (o_level[k]),
      .o_press    (o_press[k]),
      .o_release  (o_release[k]),
      .o_click    (o_click[k]),
      .o_long     (o_long[k]),
      .o_repeat   (o_repeat[k])
    );
  end

endmodule
